// File: rtl/mcash_axi3_mem.sv
`default_nettype none
// ============================================================================
// Module   : mcash_axi3_mem
// Brief    : AXI3 slave backing store for one mcash bank BIU port; independent
//            single-outstanding read/write FSMs over a 256-bit word array.
// Revision : 1.0 - initial release
// ============================================================================
module mcash_axi3_mem #(
  parameter int DEPTH_LOG2 = 10,
  parameter int RD_LAT     = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         s_axi3_arvalid_i,
  output logic         s_axi3_arready_o,
  input  logic [7:0]   s_axi3_arid_i,
  input  logic [31:0]  s_axi3_araddr_i,
  input  logic [2:0]   s_axi3_arsize_i,
  input  logic [3:0]   s_axi3_arlen_i,
  input  logic [1:0]   s_axi3_arburst_i,
  output logic         s_axi3_rvalid_o,
  input  logic         s_axi3_rready_i,
  output logic [7:0]   s_axi3_rid_o,
  output logic [255:0] s_axi3_rdata_o,
  output logic [1:0]   s_axi3_rresp_o,
  output logic         s_axi3_rlast_o,
  input  logic         s_axi3_awvalid_i,
  output logic         s_axi3_awready_o,
  input  logic [31:0]  s_axi3_awaddr_i,
  input  logic [3:0]   s_axi3_awlen_i,
  input  logic [2:0]   s_axi3_awsize_i,
  input  logic [1:0]   s_axi3_awburst_i,
  input  logic [7:0]   s_axi3_wid_i,
  input  logic         s_axi3_wvalid_i,
  output logic         s_axi3_wready_o,
  input  logic [255:0] s_axi3_wdata_i,
  input  logic [31:0]  s_axi3_wstrb_i,
  input  logic         s_axi3_wlast_i,
  output logic         s_axi3_bvalid_o,
  input  logic         s_axi3_bready_i,
  output logic [7:0]   s_axi3_bid_o,
  output logic [1:0]   s_axi3_bresp_o
);

  localparam int                    c_DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] c_IDX_ONE = 1;
  localparam logic [3:0]            c_RD_LAT  = 4'(RD_LAT);

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_BURST = 2'd2} rstate_t;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_t;

  logic [255:0] r_mem [0:c_DEPTH-1];

  rstate_t               r_rstate;
  logic                  r_arready, r_rvalid, r_rlast, r_rerr;
  logic [7:0]            r_rid;
  logic [1:0]            r_rresp;
  logic [DEPTH_LOG2-1:0] r_ridx;
  logic [3:0]            r_rlen, r_rbeat, r_rwait;

  wstate_t               r_wstate;
  logic                  r_awready, r_wready, r_bvalid, r_werr;
  logic [7:0]            r_bid;
  logic [1:0]            r_bresp;
  logic [DEPTH_LOG2-1:0] r_widx;
  logic [3:0]            r_wlen, r_wbeat;

  logic w_ar_fire, w_ar_err, w_r_fire, w_aw_fire, w_aw_err, w_w_fire, w_w_at_len;
  logic w_unused;

  assign w_ar_fire  = s_axi3_arvalid_i & r_arready;
  assign w_ar_err   = (s_axi3_arsize_i != 3'b101) | (s_axi3_arburst_i != 2'b01);
  assign w_r_fire   = r_rvalid & s_axi3_rready_i;
  assign w_aw_fire  = s_axi3_awvalid_i & r_awready;
  assign w_aw_err   = (s_axi3_awsize_i != 3'b101) | (s_axi3_awburst_i != 2'b01);
  assign w_w_fire   = s_axi3_wvalid_i & r_wready;
  assign w_w_at_len = (r_wbeat == r_wlen);
  assign w_unused   = ^{s_axi3_araddr_i[31:DEPTH_LOG2+5], s_axi3_araddr_i[4:0],
                        s_axi3_awaddr_i[31:DEPTH_LOG2+5], s_axi3_awaddr_i[4:0]};

  // Asynchronous array read: a same-cycle write lands at the edge, so the beat sees old data.
  assign s_axi3_rdata_o   = (r_rvalid && !r_rerr) ? r_mem[r_ridx] : '0;
  assign s_axi3_arready_o = r_arready;
  assign s_axi3_rvalid_o  = r_rvalid;
  assign s_axi3_rid_o     = r_rid;
  assign s_axi3_rresp_o   = r_rresp;
  assign s_axi3_rlast_o   = r_rlast;
  assign s_axi3_awready_o = r_awready;
  assign s_axi3_wready_o  = r_wready;
  assign s_axi3_bvalid_o  = r_bvalid;
  assign s_axi3_bid_o     = r_bid;
  assign s_axi3_bresp_o   = r_bresp;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b1;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rerr    <= 1'b0;
      r_rid     <= '0;
      r_rresp   <= '0;
      r_ridx    <= '0;
      r_rlen    <= '0;
      r_rbeat   <= '0;
      r_rwait   <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: if (w_ar_fire) begin
          r_arready <= 1'b0;
          r_rid     <= s_axi3_arid_i;
          r_ridx    <= s_axi3_araddr_i[DEPTH_LOG2+4:5];
          r_rlen    <= s_axi3_arlen_i;
          r_rbeat   <= '0;
          r_rerr    <= w_ar_err;
          r_rresp   <= w_ar_err ? 2'b10 : 2'b00;
          if (RD_LAT == 0) begin
            r_rstate <= R_BURST;
            r_rvalid <= 1'b1;
            r_rlast  <= (s_axi3_arlen_i == 4'd0);
          end else begin
            r_rstate <= R_WAIT;
            r_rwait  <= c_RD_LAT;
          end
        end
        R_WAIT: begin
          if (r_rwait == 4'd0) begin
            r_rstate <= R_BURST;
            r_rvalid <= 1'b1;
            r_rlast  <= (r_rlen == 4'd0);
          end else begin
            r_rwait <= r_rwait - 4'd1;
          end
        end
        R_BURST: if (w_r_fire) begin
          if (r_rlast) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
          end else begin
            r_ridx  <= r_ridx + c_IDX_ONE;
            r_rbeat <= r_rbeat + 4'd1;
            r_rlast <= ((r_rbeat + 4'd1) == r_rlen);
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b1;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_werr    <= 1'b0;
      r_bid     <= '0;
      r_bresp   <= '0;
      r_widx    <= '0;
      r_wlen    <= '0;
      r_wbeat   <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: if (w_aw_fire) begin
          r_wstate  <= W_DATA;
          r_awready <= 1'b0;
          r_wready  <= 1'b1;
          r_widx    <= s_axi3_awaddr_i[DEPTH_LOG2+4:5];
          r_wlen    <= s_axi3_awlen_i;
          r_wbeat   <= '0;
          r_werr    <= w_aw_err;
        end
        W_DATA: if (w_w_fire) begin
          r_widx <= r_widx + c_IDX_ONE;
          // Either an early wlast or reaching len closes the burst; disagreement is an error.
          if (s_axi3_wlast_i || w_w_at_len) begin
            r_wstate <= W_RESP;
            r_wready <= 1'b0;
            r_bvalid <= 1'b1;
            r_bid    <= s_axi3_wid_i;
            r_bresp  <= (r_werr || (s_axi3_wlast_i != w_w_at_len)) ? 2'b10 : 2'b00;
          end else begin
            r_wbeat <= r_wbeat + 4'd1;
          end
        end
        W_RESP: if (s_axi3_bready_i) begin
          r_wstate  <= W_IDLE;
          r_bvalid  <= 1'b0;
          r_awready <= 1'b1;
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && w_w_fire && !r_werr) begin
      for (int b = 0; b < 32; b++) begin
        if (s_axi3_wstrb_i[b]) r_mem[r_widx][8*b +: 8] <= s_axi3_wdata_i[8*b +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mcash_axi3_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_mcash_axi3_mem
// Brief    : Table-driven self-checking bench for mcash_axi3_mem with R/B scoreboards.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mcash_axi3_mem;

  localparam int DEPTH_LOG2 = 10;
  localparam int RD_LAT     = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic         arvalid = 0, arready, rvalid, rready = 0, rlast, awvalid = 0, awready;
  logic         wvalid = 0, wready, wlast = 0, bvalid, bready = 0;
  logic [7:0]   arid = 0, rid, wid = 0, bid;
  logic [31:0]  araddr = 0, awaddr = 0, wstrb = 0;
  logic [2:0]   arsize = 0, awsize = 0;
  logic [3:0]   arlen = 0, awlen = 0;
  logic [1:0]   arburst = 0, awburst = 0, rresp, bresp;
  logic [255:0] rdata, wdata = 0;

  always #5 clk = ~clk;

  mcash_axi3_mem #(.DEPTH_LOG2(DEPTH_LOG2), .RD_LAT(RD_LAT)) dut (
    .clk_i(clk), .rst_i(rst),
    .s_axi3_arvalid_i(arvalid), .s_axi3_arready_o(arready), .s_axi3_arid_i(arid),
    .s_axi3_araddr_i(araddr), .s_axi3_arsize_i(arsize), .s_axi3_arlen_i(arlen),
    .s_axi3_arburst_i(arburst), .s_axi3_rvalid_o(rvalid), .s_axi3_rready_i(rready),
    .s_axi3_rid_o(rid), .s_axi3_rdata_o(rdata), .s_axi3_rresp_o(rresp), .s_axi3_rlast_o(rlast),
    .s_axi3_awvalid_i(awvalid), .s_axi3_awready_o(awready), .s_axi3_awaddr_i(awaddr),
    .s_axi3_awlen_i(awlen), .s_axi3_awsize_i(awsize), .s_axi3_awburst_i(awburst),
    .s_axi3_wid_i(wid), .s_axi3_wvalid_i(wvalid), .s_axi3_wready_o(wready),
    .s_axi3_wdata_i(wdata), .s_axi3_wstrb_i(wstrb), .s_axi3_wlast_i(wlast),
    .s_axi3_bvalid_o(bvalid), .s_axi3_bready_i(bready), .s_axi3_bid_o(bid), .s_axi3_bresp_o(bresp)
  );

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    int          len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [7:0]  id;
    logic [31:0] strb;
    int          wlast_at;
    logic [15:0] rpat;
    int          seed;
    logic [1:0]  exp_resp;
  } op_t;

  typedef struct {
    logic [255:0] data;
    logic [1:0]   resp;
    logic         last;
    logic [7:0]   id;
  } rbeat_t;

  typedef struct {
    logic [7:0] id;
    logic [1:0] resp;
  } bresp_t;

  op_t          ops[$];
  rbeat_t       rsb[$];
  bresp_t       bsb[$];
  logic [255:0] model [0:(1<<DEPTH_LOG2)-1];
  int           total = 0;
  int           bad   = 0;

  task automatic chk(input string name, input logic [299:0] act, input logic [299:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] mkdata(input int seed, input int beat);
    logic [255:0] d;
    if (seed == 0) return '1;
    for (int k = 0; k < 8; k++) d[k*32 +: 32] = (seed * 32'h0100_0193) ^ (beat << 8) ^ k;
    return d;
  endfunction

  function automatic op_t mk(input bit w, input logic [31:0] a, input int l, input logic [2:0] s,
                             input logic [1:0] bu, input logic [7:0] id, input logic [31:0] st,
                             input int wl, input logic [15:0] rp, input int sd, input logic [1:0] er);
    op_t o;
    o.is_wr = w; o.addr = a; o.len = l; o.size = s; o.burst = bu; o.id = id;
    o.strb = st; o.wlast_at = wl; o.rpat = rp; o.seed = sd; o.exp_resp = er;
    return o;
  endfunction

  task automatic do_write(input op_t o);
    int  t = 0;
    int  idx = int'(o.addr[DEPTH_LOG2+4:5]);
    bit  err = (o.size != 3'b101) || (o.burst != 2'b01);
    bresp_t e;
    awvalid = 1; awaddr = o.addr; awlen = 4'(o.len); awsize = o.size; awburst = o.burst;
    while (!awready && t < 50) begin @(posedge clk); #1; t++; end
    chk("aw_ready_wait", 300'(t < 50), 300'(1));
    @(posedge clk); #1;
    awvalid = 0;
    e.id = o.id; e.resp = o.exp_resp;
    bsb.push_back(e);
    for (int i = 0; i < 16; i++) begin
      wvalid = 1; wid = o.id; wdata = mkdata(o.seed, i); wstrb = o.strb; wlast = (i == o.wlast_at);
      t = 0;
      while (!wready && t < 50) begin @(posedge clk); #1; t++; end
      chk("w_ready_wait", 300'(t < 50), 300'(1));
      @(posedge clk);
      if (!err)
        for (int b = 0; b < 32; b++)
          if (o.strb[b]) model[idx][8*b +: 8] = wdata[8*b +: 8];
      idx = (idx + 1) % (1 << DEPTH_LOG2);
      #1;
      if (i == o.wlast_at || i == o.len) break;
    end
    wvalid = 0; wlast = 0;
    chk("wready_after_burst", 300'(wready), 300'(0));
    bready = 1; t = 0;
    while (!bvalid && t < 50) begin @(posedge clk); #1; t++; end
    e = bsb.pop_front();
    chk("bresp_bid", {290'(bvalid), bid, bresp}, {290'(1), e.id, e.resp});
    @(posedge clk); #1;
    bready = 0;
    chk("bvalid_drop", {298'(bvalid), 2'(awready)}, {298'(0), 2'(1)});
  endtask

  task automatic wait_first_beat();
    int n = 0;
    while (!rvalid && n < 50) begin @(posedge clk); #1; n++; end
    chk("rd_latency", 300'(n), 300'(RD_LAT + 1));
  endtask

  task automatic ar_handshake(input op_t o);
    int t = 0;
    arvalid = 1; araddr = o.addr; arlen = 4'(o.len); arsize = o.size; arburst = o.burst; arid = o.id;
    while (!arready && t < 50) begin @(posedge clk); #1; t++; end
    chk("ar_ready_wait", 300'(t < 50), 300'(1));
    @(posedge clk); #1;
    arvalid = 0;
  endtask

  task automatic do_read(input op_t o);
    int     idx = int'(o.addr[DEPTH_LOG2+4:5]);
    int     k = 0, got = 0, guard = 0;
    bit     stalled;
    rbeat_t e, snap;
    ar_handshake(o);
    for (int b = 0; b <= o.len; b++) begin
      e.data = (o.exp_resp == 2'b10) ? '0 : model[idx];
      e.resp = o.exp_resp; e.last = (b == o.len); e.id = o.id;
      rsb.push_back(e);
      idx = (idx + 1) % (1 << DEPTH_LOG2);
    end
    wait_first_beat();
    while (got < o.len + 1 && guard < 200) begin
      rready = o.rpat[k % 16];
      stalled = 0;
      if (rvalid) begin
        k++;
        if (rready) begin
          e = rsb.pop_front();
          chk($sformatf("rbeat%0d", got), {rdata, rresp, rlast, rid}, {e.data, e.resp, e.last, e.id});
          got++;
        end else begin
          stalled = 1;
          snap.data = rdata; snap.resp = rresp; snap.last = rlast; snap.id = rid;
        end
      end
      @(posedge clk); #1;
      guard++;
      if (stalled)
        chk("stall_hold", {rvalid, rdata, rresp, rlast, rid},
            {1'b1, snap.data, snap.resp, snap.last, snap.id});
    end
    rready = 0;
    chk("beats_done", 300'(got), 300'(o.len + 1));
    chk("rd_idle_after", {298'(rvalid), 2'(arready)}, {298'(0), 2'(1)});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < (1 << DEPTH_LOG2); i++) model[i] = '0;
    ops.push_back(mk(1, 32'h40,   1, 3'b101, 2'b01, 8'h11, '1,           1, 16'hFFFF, 1, 2'b00));
    ops.push_back(mk(0, 32'h40,   1, 3'b101, 2'b01, 8'h22, '0,           0, 16'hFFFF, 0, 2'b00));
    ops.push_back(mk(1, 32'h40,   0, 3'b101, 2'b01, 8'h12, 32'h0000_000F, 0, 16'hFFFF, 0, 2'b00));
    ops.push_back(mk(0, 32'h40,   0, 3'b101, 2'b01, 8'h23, '0,           0, 16'hFFFF, 0, 2'b00));
    ops.push_back(mk(0, 32'h8040, 1, 3'b101, 2'b01, 8'h24, '0,           0, 16'hFFFF, 0, 2'b00));
    ops.push_back(mk(1, 32'h7FE0, 1, 3'b101, 2'b01, 8'h13, '1,           1, 16'hFFFF, 2, 2'b00));
    ops.push_back(mk(0, 32'h7FE0, 1, 3'b101, 2'b01, 8'h25, '0,           0, 16'hFFFF, 0, 2'b00));
    ops.push_back(mk(1, 32'h100,  3, 3'b101, 2'b01, 8'h14, '1,           3, 16'hFFFF, 3, 2'b00));
    ops.push_back(mk(0, 32'h100,  3, 3'b101, 2'b01, 8'h26, '0,           0, 16'h9999, 0, 2'b00));
    ops.push_back(mk(0, 32'h100,  2, 3'b100, 2'b01, 8'h27, '0,           0, 16'hFFFF, 0, 2'b10));
    ops.push_back(mk(1, 32'h100,  3, 3'b101, 2'b01, 8'h15, '1,           1, 16'hFFFF, 4, 2'b10));
    ops.push_back(mk(0, 32'h100,  3, 3'b101, 2'b01, 8'h28, '0,           0, 16'hFFFF, 0, 2'b00));
    ops.push_back(mk(1, 32'h200,  1, 3'b101, 2'b01, 8'h16, '1,           1, 16'hFFFF, 5, 2'b00));
    ops.push_back(mk(1, 32'h200,  1, 3'b101, 2'b10, 8'h17, '1,           1, 16'hFFFF, 6, 2'b10));
    ops.push_back(mk(0, 32'h200,  1, 3'b101, 2'b01, 8'h29, '0,           0, 16'hFFFF, 0, 2'b00));
    ops.push_back(mk(1, 32'h240,  1, 3'b101, 2'b01, 8'h18, '1,           7, 16'hFFFF, 7, 2'b10));
    ops.push_back(mk(0, 32'h240,  1, 3'b101, 2'b01, 8'h2A, '0,           0, 16'hFFFF, 0, 2'b00));

    repeat (3) @(posedge clk);
    #1; rst = 0;
    chk("rst_ready", {298'(arready), 2'(awready)}, {298'(1), 2'(1)});
    chk("rst_valids", 300'({rvalid, rlast, wready, bvalid}), 300'(0));
    chk("rst_ids", 300'({rid, rresp, bid, bresp}), 300'(0));
    chk("rst_rdata", 300'(rdata), 300'(0));

    wvalid = 1; wdata = '1; wstrb = '1; wlast = 1;
    for (int i = 0; i < 3; i++) begin
      chk("w_before_aw", 300'(wready), 300'(0));
      @(posedge clk); #1;
    end
    wvalid = 0; wlast = 0;

    foreach (ops[i]) begin
      if (ops[i].is_wr) do_write(ops[i]);
      else do_read(ops[i]);
    end

    // Reset arrives while beat 2 of a 4-beat read is on the bus.
    ar_handshake(mk(0, 32'h100, 3, 3'b101, 2'b01, 8'h31, '0, 0, 16'hFFFF, 0, 2'b00));
    wait_first_beat();
    rready = 1;
    repeat (2) @(posedge clk);
    #1; rready = 0;
    chk("pre_rst_beat2", 300'({rvalid, rlast}), 300'(2'b10));
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("rst_mid_read", 300'({rvalid, rlast, arready}), 300'(3'b001));
    rready = 1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("no_beats_after_rst", 300'(rvalid), 300'(0));
    end
    rready = 0;
    do_read(mk(0, 32'h100, 3, 3'b101, 2'b01, 8'h32, '0, 0, 16'hFFFF, 0, 2'b00));

    chk("scoreboards_empty", 300'(rsb.size() + bsb.size()), 300'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
